// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register-file writeback arbiter.
// Request bundle, arbiter state encoding and width constants.
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  typedef enum logic {
    PIPE_PRI = 1'b0,
    LSU_PRI  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_scoreboard.sv
// Pending-write scoreboard for long-latency destinations.
// Ports: set (issue), clear (retiring lsu write), rs1/rs2 busy lookup.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int N_REG = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_valid,
  input  logic [REG_IDX_W-1:0] set_rd,
  input  logic                 clr_valid,
  input  logic [REG_IDX_W-1:0] clr_rd,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  logic [N_REG-1:0] pending_q;
  logic [N_REG-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_valid)
      pending_d[clr_rd] = 1'b0;
    // A new issue to the retiring register keeps it outstanding.
    if (set_valid && set_rd != '0)
      pending_d[set_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending_q <= '0;
    else
      pending_q <= pending_d;
  end

  assign rs1_busy = (rs1_index != '0) && pending_q[rs1_index];
  assign rs2_busy = (rs2_index != '0) && pending_q[rs2_index];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates pipe and lsu writebacks onto one register-file write port.
// Ports: pipe/lsu valid-ready requests, issue marking, rs lookups, wb port.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int N_REG        = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid,
  input  logic [REG_IDX_W-1:0] pipe_rd,
  input  logic [XLEN-1:0]      pipe_data,
  output logic                 pipe_ready,
  input  logic                 lsu_valid,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 lsu_ready,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 wb_en,
  output logic [REG_IDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]      wb_data
);

  localparam logic [3:0] LIM_M1 = 4'(STARVE_LIMIT - 1);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  wb_req_t    wb_q, wb_d;
  logic       wb_lsu_q, wb_lsu_d;
  logic       pipe_gnt, lsu_gnt;

  always_comb begin
    pipe_gnt = 1'b0;
    lsu_gnt  = 1'b0;
    unique case (state_q)
      PIPE_PRI: begin
        pipe_gnt = pipe_valid;
        lsu_gnt  = lsu_valid && !pipe_valid;
      end
      LSU_PRI: begin
        lsu_gnt  = lsu_valid;
        pipe_gnt = pipe_valid && !lsu_valid;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    if (lsu_gnt || !lsu_valid)
      starve_d = '0;
    else if (state_q == PIPE_PRI)
      starve_d = starve_q + 4'd1;
    if (state_q == PIPE_PRI) begin
      if (lsu_valid && !lsu_gnt && starve_q == LIM_M1)
        state_d = LSU_PRI;
    end else if (lsu_gnt || !lsu_valid) begin
      state_d = PIPE_PRI;
    end
  end

  // rd/data hold when idle; rd==0 grants stage but never enable.
  always_comb begin
    wb_d       = wb_q;
    wb_d.valid = 1'b0;
    wb_lsu_d   = 1'b0;
    if (pipe_gnt) begin
      wb_d.valid = pipe_rd != '0;
      wb_d.rd    = pipe_rd;
      wb_d.data  = pipe_data;
    end else if (lsu_gnt) begin
      wb_d.valid = lsu_rd != '0;
      wb_d.rd    = lsu_rd;
      wb_d.data  = lsu_data;
      wb_lsu_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PIPE_PRI;
      starve_q <= '0;
      wb_q     <= '0;
      wb_lsu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wb_q     <= wb_d;
      wb_lsu_q <= wb_lsu_d;
    end
  end

  wb_scoreboard #(.N_REG(N_REG)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_valid (issue_valid),
    .set_rd    (issue_rd),
    .clr_valid (wb_q.valid && wb_lsu_q),
    .clr_rd    (wb_q.rd),
    .rs1_index (rs1_index),
    .rs2_index (rs2_index),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy)
  );

  assign pipe_ready = pipe_gnt;
  assign lsu_ready  = lsu_gnt;
  assign wb_en      = wb_q.valid;
  assign wb_rd      = wb_q.rd;
  assign wb_data    = wb_q.data;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two writeback sources: the in-order pipeline (pipe) and the long-latency load/store unit (lsu).
- Registers the granted write into a one-entry stage that drives the register-file write port (wb_en, wb_rd, wb_data).
- Holds a per-register pending scoreboard for outstanding long-latency destinations and reports rs1/rs2 busy status to hazard logic.

Parameters:
- STARVE_LIMIT, 4, consecutive lsu-blocked cycles before lsu gets priority for one grant (range 1..15).
- N_REG, 32, number of architectural registers (scoreboard depth).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pipe_valid  in  1  pipeline writeback request
- pipe_rd  in  5  pipeline destination index
- pipe_data  in  32  pipeline writeback data
- pipe_ready  out  1  pipeline request accepted this cycle
- lsu_valid  in  1  lsu writeback request
- lsu_rd  in  5  lsu destination index
- lsu_data  in  32  lsu writeback data
- lsu_ready  out  1  lsu request accepted this cycle
- issue_valid  in  1  long-latency op issued; marks issue_rd pending
- issue_rd  in  5  destination index of issued long-latency op
- rs1_index  in  5  source 1 lookup
- rs2_index  in  5  source 2 lookup
- rs1_busy  out  1  rs1 has an outstanding write
- rs2_busy  out  1  rs2 has an outstanding write
- wb_en  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- wb_data  out  32  register-file write data

Behaviour:
- Reset (async, rst=1): wb_en=0, wb_rd=0, wb_data=0, all pending bits=0, starve_cnt=0, FSM=PIPE_PRI. pipe_ready/lsu_ready are combinational and read 0 when no valid is present.
- Handshake: a transfer occurs when valid&&ready in the same cycle. At most one grant per cycle. Ready depends only on the valids and the FSM state, never on itself.
- FSM states PIPE_PRI and LSU_PRI.
  - PIPE_PRI: pipe_valid wins; lsu is granted only when pipe_valid=0.
  - LSU_PRI: lsu_valid wins; pipe is granted only when lsu_valid=0.
- starve_cnt (4 bits):
  - increments in PIPE_PRI each cycle with lsu_valid=1 and lsu_ready=0;
  - clears on any lsu grant or when lsu_valid=0.
  - When starve_cnt==STARVE_LIMIT-1 and lsu is blocked again, next state is LSU_PRI.
- LSU_PRI -> PIPE_PRI after one lsu grant, or when lsu_valid=0.
- Latency: grant in cycle N -> wb_en=1 with that rd/data in cycle N+1 -> register file written at end of N+1. With no grant in N, wb_en=0 in N+1 and wb_rd/wb_data hold their last values.
- rd==0 requests:
  - are accepted (ready asserted normally) but produce wb_en=0 in N+1;
  - issue_rd==0 never sets a pending bit.
- Scoreboard:
  - pending[issue_rd] sets at the edge after issue_valid=1.
  - pending[r] clears at the end of the cycle in which wb_en=1 and wb_rd=r and the staged write came from lsu. A one-bit stage tag records the source.
  - Pipe writes never clear pending.
  - Set and clear of the same r in one cycle: set wins (new op outstanding).
- rsX_busy = pending[rsX_index] (combinational); index 0 always reads not busy.
  - For an lsu write granted in N: busy stays 1 through N+1 and drops in N+2, the first cycle the register file returns the new value.
- Simultaneous pipe and lsu writes to the same rd: the granted one is staged first, the other follows in a later cycle, so the last grant wins.
- Reset mid-operation: the staged write is discarded (wb_en=0 immediately) and the scoreboard is cleared.

Decomposition:
- Shared package holds:
  - typedef wb_req_t {logic valid; logic [4:0] rd; logic [31:0] data;}
  - enum arb_state_e {PIPE_PRI, LSU_PRI}
  - constants REG_IDX_W=5, XLEN=32
- One sub-module, wb_scoreboard: pending vector, set/clear/precedence, rs1/rs2 lookup.
- Arbitration FSM, starve counter and writeback stage stay in the top module.

Test Plan:
- pipe_valid=1, pipe_rd=5, pipe_data=0xDEADBEEF only -> pipe_ready=1; next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF.
- issue_valid, issue_rd=7; later lsu_valid, lsu_rd=7, lsu_data=0x1234 granted in cycle N -> rs1_index=7 gives rs1_busy=1 from issue through N+1, 0 in N+2; wb_en=1, wb_rd=7 in N+1.
- pipe_valid and lsu_valid held continuously, STARVE_LIMIT=4 -> lsu blocked 4 cycles, lsu_ready=1 in cycle 5 with pipe_ready=0, then pipe priority resumes.
- pipe_valid, pipe_rd=0, pipe_data=0xFFFFFFFF -> pipe_ready=1, wb_en stays 0; issue_rd=0 -> rs1_busy=0 for rs1_index=0.
- issue_valid with issue_rd=9 in the same cycle a staged lsu write to rd 9 retires -> pending[9] remains 1, rs2_busy=1 for rs2_index=9.
- rst asserted asynchronously mid-cycle with a staged write and pending bits {3,9} -> wb_en=0 immediately, rs1_busy=rs2_busy=0 for indices 3 and 9, FSM=PIPE_PRI after release.
